// File: rtl/dmem_lsu_ctrl.sv
// RV32I load/store sequencer for a 64-word single-port data memory; sub-word stores use read-modify-write.
// Define DMEM_LSU_MISALIGN_TRAP_EN to turn misaligned accesses into errors (otherwise they are aligned down).
module dmem_lsu_ctrl #(
    parameter int DEPTH_WORDS = 64,
    parameter int IDX_W       = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_READ, S_WRITE, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         lane_q, lane_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        merge_q, merge_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               mem_we_raw;
    logic [31:0]        word_addr;

    function automatic logic req_error(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        logic bad_f3;
        logic bad_range;
        bad_f3    = we ? (f3 > 3'b010) : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        bad_range = (addr[31:2] >= 30'(DEPTH_WORDS));
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
        return bad_f3 | bad_range
             | (f3[1:0] == 2'b01 && addr[0])
             | (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);
`else
        // Lane selection ignores the low address bits below the access size, which aligns down.
        return bad_f3 | bad_range;
`endif
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] lane);
        logic [31:0]        byte_sh;
        logic [31:0]        half_sh;
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        logic signed [31:0] ext_s;
        logic [31:0]        res;
        byte_sh = word >> {lane, 3'b000};
        half_sh = word >> {lane[1], 4'b0000};
        b_s     = signed'(byte_sh[7:0]);
        h_s     = signed'(half_sh[15:0]);
        ext_s   = '0;
        case (f3)
            3'b000:  begin ext_s = b_s; res = ext_s; end
            3'b001:  begin ext_s = h_s; res = ext_s; end
            3'b100:  res = {24'b0, byte_sh[7:0]};
            3'b101:  res = {16'b0, half_sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [2:0] f3, input logic [1:0] lane);
        logic [31:0] mask;
        logic [31:0] data;
        if (f3[1:0] == 2'b00) begin
            mask = 32'h0000_00FF << {lane, 3'b000};
            data = {24'b0, wd[7:0]} << {lane, 3'b000};
        end else begin
            mask = 32'h0000_FFFF << {lane[1], 4'b0000};
            data = {16'b0, wd[15:0]} << {lane[1], 4'b0000};
        end
        return (old & ~mask) | (data & mask);
    endfunction

    assign word_addr = {{(30-IDX_W){1'b0}}, idx_q, 2'b00};

    always_comb begin
        state_d    = state_q;
        funct3_d   = funct3_q;
        idx_d      = idx_q;
        lane_d     = lane_q;
        wdata_d    = wdata_q;
        merge_d    = merge_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        mem_we_raw = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    funct3_d = req_funct3;
                    idx_d    = req_addr[IDX_W+1:2];
                    lane_d   = req_addr[1:0];
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    err_d    = req_error(req_we, req_funct3, req_addr);
                    if (err_d)                        state_d = S_RESP;
                    else if (!req_we)                 state_d = S_LOAD;
                    else if (req_funct3[1:0] == 2'b10) state_d = S_WRITE;
                    else                              state_d = S_READ;
                end
            end
            S_LOAD: begin
                mem_addr = word_addr;
                rdata_d  = load_extend(mem_rdata, funct3_q, lane_q);
                state_d  = S_RESP;
            end
            S_READ: begin
                mem_addr = word_addr;
                merge_d  = mem_rdata;
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                mem_addr   = word_addr;
                mem_we_raw = 1'b1;
                mem_wdata  = (funct3_q[1:0] == 2'b10) ? wdata_q
                                                      : store_merge(merge_q, wdata_q, funct3_q, lane_q);
                state_d    = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Gating with rst_n keeps a reset that lands in WRITE from corrupting memory.
    assign mem_we    = mem_we_raw & rst_n;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            funct3_q <= '0;
            idx_q    <= '0;
            lane_q   <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            idx_q    <= idx_d;
            lane_q   <= lane_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

endmodule
